// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous prefetch FIFO.
package fifo_pkg;

    // Ceiling log2 for elaboration-time sizing; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Number of entries for a given log2 capacity.
    function automatic int depth_of(input int depth_width);
        return 1 << depth_width;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) output that holds while no read is issued.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [DEPTH_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [DEPTH_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data
);

    localparam int DEPTH = depth_of(DEPTH_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port.
    // NOTE: storage has no reset so it maps onto block RAM; validity of its
    // contents is tracked by the controller, never by the array itself.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_prefetch_fifo.sv
// Single-clock first-word-fall-through FIFO. A two-stage prefetch path
// (RAM read register, then output register) keeps the head word presented
// on rd_data whenever the FIFO holds data.
module sync_prefetch_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH_WIDTH   = 10,
    parameter int AFULL_THRESH  = 2**DEPTH_WIDTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    output logic                   wr_vld,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DEPTH_WIDTH:0]   count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH = depth_of(DEPTH_WIDTH);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CW    = DEPTH_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CW-1:0]         mem_cnt;     // words in RAM not yet read out
    logic                  s1_vld;      // RAM read register holds a word
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  do_wr;
    logic                  do_pop;
    logic                  out_load;
    logic                  s1_free;
    logic                  rd_issue;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         mem_cnt_next;

    fifo_sdp_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WIDTH (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Transfer decisions for this cycle; flush suppresses every transfer.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        do_wr        = wr_en & wr_vld & ~flush;
        do_pop       = rd_en & rd_vld & ~flush;
        out_load     = s1_vld & (~rd_vld | do_pop) & ~flush;
        s1_free      = ~s1_vld | out_load;
        rd_issue     = (mem_cnt != '0) & s1_free & ~flush;
        count_next   = count;
        mem_cnt_next = mem_cnt;
        if (flush) begin
            count_next   = '0;
            mem_cnt_next = '0;
        end else begin
            case ({do_wr, do_pop})
                2'b10:   count_next = count + ONE_C;
                2'b01:   count_next = count - ONE_C;
                default: count_next = count;
            endcase
            case ({do_wr, rd_issue})
                2'b10:   mem_cnt_next = mem_cnt + ONE_C;
                2'b01:   mem_cnt_next = mem_cnt - ONE_C;
                default: mem_cnt_next = mem_cnt;
            endcase
        end
    end

    // RAM pointers and RAM occupancy; pointers wrap naturally modulo DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            mem_cnt <= mem_cnt_next;
        end
    end

    // Prefetch pipeline: RAM read stage feeds the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else if (flush) begin
            s1_vld <= 1'b0;
            rd_vld <= 1'b0;
        end else begin
            if (rd_issue) begin
                s1_vld <= 1'b1;
            end else if (out_load) begin
                s1_vld <= 1'b0;
            end
            if (out_load) begin
                rd_vld  <= 1'b1;
                rd_data <= ram_q;
            end else if (do_pop) begin
                rd_vld <= 1'b0;
            end
        end
    end

    // Occupancy, registered status flags and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            wr_vld       <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_next;
            wr_vld       <= count_next < DEPTH_C;
            almost_full  <= count_next >= AFULL_C;
            almost_empty <= count_next <= AEMPTY_C;
            overflow     <= wr_en & ~wr_vld & ~flush;
            underflow    <= rd_en & ~rd_vld & ~flush;
        end
    end

endmodule

// File: doc/sync_prefetch_fifo.md
Name: sync_prefetch_fifo

Overview:
- Single-clock, first-word-fall-through (prefetch) FIFO: head word is presented on rd_data with rd_vld high and no read request needed.
- Generalised successor to the dual-clock prefetch FIFO wrapper: parametrised width and depth, programmable almost-full/almost-empty flags, occupancy count, synchronous flush, and overflow/underflow pulses.
- Used between audio pipeline stages that share one clock domain.

Parameters:
- DATA_WIDTH, 16, data width in bits (1..1152).
- DEPTH_WIDTH, 10, log2 of capacity; DEPTH = 2**DEPTH_WIDTH entries (4..20).
- AFULL_THRESH, 2**DEPTH_WIDTH-4, almost_full asserted when count >= AFULL_THRESH.
- AEMPTY_THRESH, 4, almost_empty asserted when count <= AEMPTY_THRESH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all contents; dominates wr_en and rd_en.
- wr_en  in  1  write request.
- wr_vld  out  1  FIFO can accept data (count < DEPTH); a write occurs on wr_en & wr_vld.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  consumer accepts the head word; a pop occurs on rd_en & rd_vld.
- rd_vld  out  1  rd_data holds a valid head word.
- rd_data  out  DATA_WIDTH  head word; stable while rd_vld & !rd_en.
- count  out  DEPTH_WIDTH+1  total words held, including the prefetch stages.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- overflow  out  1  one-cycle pulse: wr_en & !wr_vld in the previous cycle.
- underflow  out  1  one-cycle pulse: rd_en & !rd_vld in the previous cycle.

Behaviour:
- Reset (rst_n low, async): pointers=0, count=0, rd_vld=0, rd_data=0, wr_vld=0 while rst_n low, then 1 from the first clock edge after release; almost_empty=1, almost_full=0, overflow=underflow=0.
- Storage: memory array with registered (1-cycle) read. A prefetch pipeline (memory read register, then output register) keeps the output register filled whenever data exists. Memory must never be written when full.
- Latency: a write into an empty FIFO at edge N gives rd_vld=1 with that data after edge N+2. A pop at edge N with further data queued gives the next word on rd_data after edge N; no bubble in steady-state streaming.
- Throughput: one write and one read per cycle sustained; simultaneous write and pop leave count unchanged.
- count: +1 on write only, -1 on pop only, unchanged on both or neither. Includes words in flight in the prefetch stages. Maximum value is DEPTH.
- Full (count==DEPTH):
  - wr_vld=0; wr_en is ignored (data dropped) and produces an overflow pulse.
  - A pop and a wr_en in the same cycle: the write is still refused, because wr_vld is a registered function of count.
- Empty (rd_vld=0): rd_en is ignored, underflow pulses, rd_data holds its last value.
- Pointer wrap: read and write pointers wrap modulo DEPTH; full and empty are decided from count, never from pointer equality alone.
- Flags: almost_full and almost_empty are registered and updated in the same cycle as count.
- flush: at the edge, pointers, count and prefetch valids clear. The next cycle gives rd_vld=0, count=0, wr_vld=1. Any wr_en or rd_en in the flush cycle is discarded, with no overflow or underflow pulse.
- Reset mid-stream: all state clears immediately; no partial word is output after release.
- rd_data is driven only from the output register, never combinationally from memory.

Decomposition:
- Package fifo_pkg: function clog2, and localparam-derived DEPTH computed from DEPTH_WIDTH.
- Sub-module fifo_sdp_ram: simple dual-port RAM with a 1-cycle registered read (DATA_WIDTH, DEPTH_WIDTH), inferable as DRM.
- Top module: pointers, count, flag logic, 2-stage prefetch control.

Test Plan:
- Reset then single write 0xA5A5 at edge 1, rd_en=0 -> rd_vld=1 and rd_data=0xA5A5 after edge 3; count=1; almost_empty=1.
- DEPTH_WIDTH=4: write 16 words 0..15 with no reads -> wr_vld=0 after 16th write, count=16, almost_full=1 from count=12; 17th wr_en -> overflow pulse, data 0x10 never read.
- Continuous write and rd_en=1 for 100 cycles after prefill of 3 -> rd_data strictly increasing with no gaps, count stays 3, rd_vld stays 1.
- Empty FIFO, rd_en=1 -> underflow pulse one cycle later, rd_vld=0, count=0.
- Fill with 10 words, assert flush with wr_en=1 and rd_en=1 -> next cycle count=0, rd_vld=0, no overflow or underflow pulse; subsequent write 0x1234 is read first.
- Write 40 words with random rd_en on DEPTH_WIDTH=4 to force pointer wrap -> output order matches the scoreboard; rst_n pulsed low mid-stream -> rd_vld=0 and count=0 asynchronously.
